// File: rtl/pedal_pkg.sv
// Shared types and conversion helpers for the pedal audio path.
// adc_to_sample turns an offset-binary ADC word into a left-justified signed sample.
package pedal_pkg;

  localparam int ADC_W    = 12;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Flipping the MSB moves mid-scale (0x800) to zero.
  function automatic sample_t adc_to_sample(input logic [ADC_W-1:0] adc);
    return sample_t'({~adc[ADC_W-1], adc[ADC_W-2:0], 4'b0000});
  endfunction

  function automatic sample_t sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return 16'sh7FFF;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return sample_t'(v[15:0]);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle. head_o reads zero while empty.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count_q says so.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/adc_sample_conditioner.sv
// Decimates the free-running ADC word to FS_HZ, removes DC with a one-pole
// high-pass and streams signed 16-bit samples through a small FIFO.
module adc_sample_conditioner
  import pedal_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FS_HZ      = 48_000,
  parameter int K          = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [ADC_W-1:0] ADC_CH,
  input  logic             BYPASS,
  input  logic             CLEAR_OVF,
  output logic             SAMPLE_VALID,
  output logic [15:0]      SAMPLE_DATA,
  input  logic             SAMPLE_READY,
  output logic             OVERFLOW
);

  localparam int DIV   = CLK_HZ / FS_HZ;
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick;
  logic             s1_valid_q;
  sample_t          x_q;
  logic             s2_valid_q;
  sample_t          y_q, y_d;
  sample_t          x_prev_q, x_prev_d;
  sample_t          y_prev_q, y_prev_d;
  logic signed [17:0] acc;
  logic             ovf_q, ovf_d;
  logic             pop, drop, fifo_full, fifo_empty;

  assign tick = (count_q == CNT_W'(DIV - 1));

  // Stage 2: 18-bit accumulator leaves headroom for a full-scale step on top of y_prev.
  always_comb begin
    count_d  = tick ? '0 : count_q + 1'b1;
    acc      = 18'(x_q) - 18'(x_prev_q) + 18'(y_prev_q) - 18'(y_prev_q >>> K);
    y_d      = y_q;
    x_prev_d = x_prev_q;
    y_prev_d = y_prev_q;
    if (s1_valid_q) begin
      x_prev_d = x_q;
      if (BYPASS) begin
        y_d      = x_q;
        y_prev_d = '0;
      end else begin
        y_d      = sat16(acc);
        y_prev_d = sat16(acc);
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      count_q    <= '0;
      s1_valid_q <= 1'b0;
      x_q        <= '0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      x_prev_q   <= '0;
      y_prev_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      s1_valid_q <= tick;
      if (tick) x_q <= adc_to_sample(ADC_CH);
      s2_valid_q <= s1_valid_q;
      y_q        <= y_d;
      x_prev_q   <= x_prev_d;
      y_prev_q   <= y_prev_d;
      ovf_q      <= ovf_d;
    end
  end

  // Stream: a sample transfers on any rising edge where SAMPLE_VALID && SAMPLE_READY;
  // SAMPLE_DATA holds while VALID is high and READY is low.
  assign pop  = SAMPLE_VALID && SAMPLE_READY;
  assign drop = s2_valid_q && fifo_full && !pop;

  always_comb begin
    ovf_d = ovf_q;
    if (CLEAR_OVF) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk_i   (CLOCK),
    .rst_ni  (RESET),
    .push_i  (s2_valid_q),
    .data_i  (y_q),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (SAMPLE_DATA)
  );

  assign SAMPLE_VALID = !fifo_empty;
  assign OVERFLOW     = ovf_q;

endmodule

// File: doc/adc_sample_conditioner.md
# adc_sample_conditioner

Downstream consumer of the ADC controller's channel-0 result. Decimates the continuously refreshed 12-bit ADC word to a fixed audio sample rate and converts offset-binary to signed 16-bit. Removes DC bias with a first-order high-pass and buffers samples in a small FIFO behind a valid/ready stream. The stream feeds the effect pipeline.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- FS_HZ, 48_000, output sample rate; DIV = CLK_HZ / FS_HZ (integer divide, 1041 at defaults)
- K, 10, DC-blocker pole shift (pole = 1 - 2^-K)
- FIFO_DEPTH, 4, output buffer entries (power of two, >= 2)

Ports:
- CLOCK  in  1  system clock, 50 MHz; all logic on rising edge
- RESET  in  1  asynchronous, active-low reset; deassertion is synchronous to CLOCK
- ADC_CH  in  12  ADC channel-0 result, offset binary, same clock domain
- BYPASS  in  1  1 = skip DC blocker and output the converted sample directly
- CLEAR_OVF  in  1  single-cycle pulse that clears OVERFLOW
- SAMPLE_VALID  out  1  FIFO not empty
- SAMPLE_DATA  out  16  signed sample at FIFO head (show-ahead)
- SAMPLE_READY  in  1  consumer accepts the head when VALID && READY
- OVERFLOW  out  1  sticky flag; a sample was dropped because the FIFO was full

## Operation
- Tick counter runs 0..DIV-1 and wraps. TICK = (count == DIV-1).
- Stage 1 (TICK): capture x = {~ADC_CH[11], ADC_CH[10:0], 4'b0000} as signed 16-bit. 0x800 maps to 0x0000, 0xFFF to 0x7FF0, 0x000 to 0x8000.
- Stage 2 (cycle after TICK): compute y.
  - Blocker in 18-bit signed: y = x - x_prev + y_prev - (y_prev >>> K).
  - Saturate y to [-32768, 32767].
  - Store x_prev <= x and y_prev <= saturated y.
- BYPASS=1: y = x. x_prev is still updated; y_prev is forced to 0. BYPASS is sampled at stage 2.
- Push: stage-2 result is pushed into the FIFO.
  - FIFO full and no pop that cycle: drop the sample and set OVERFLOW.
  - FIFO full with a pop in the same cycle: push is accepted and count stays FIFO_DEPTH.
- Pop: occurs on SAMPLE_VALID && SAMPLE_READY. FIFO order is strict FIFO.
- OVERFLOW: sticky until CLEAR_OVF. If a drop and CLEAR_OVF occur in the same cycle, the set wins.
- Reset values (asynchronous, with RESET low):
  - count = 0, stage valids = 0, x_prev = 0, y_prev = 0
  - FIFO empty, SAMPLE_VALID = 0, SAMPLE_DATA = 0, OVERFLOW = 0
- Reset mid-operation discards all buffered samples and blocker state.

## Timing
- First TICK occurs DIV cycles after RESET deasserts (count reaches DIV-1).
- ADC_CH is sampled on the TICK edge.
- Push happens 2 cycles after the TICK edge. SAMPLE_VALID rises in the cycle after the push, so the first sample is visible 3 cycles after TICK.
- SAMPLE_DATA is stable while VALID && !READY.
- Sustained throughput: one sample per DIV cycles. The consumer may stall up to FIFO_DEPTH sample periods without loss.

## Structure
- Shared package pedal_pkg:
  - ADC_W = 12, SAMPLE_W = 16
  - typedef sample_t = logic signed [15:0]
  - function adc_to_sample (offset-binary to left-justified signed)
  - function sat16 (18-bit to 16-bit saturation)
- Sub-module sample_fifo: parameterised depth/width synchronous FIFO with push, pop, full, empty, head and same-cycle push+pop on full.
- The divider, pipeline and blocker stay in adc_sample_conditioner.

## Test plan
- BYPASS=1, ADC_CH=0x800, READY=1 -> one SAMPLE_DATA=0x0000 every 1041 cycles; first VALID at cycle 1041+3 after reset release.
- BYPASS=1, ADC_CH=0xFFF then 0x000 -> SAMPLE_DATA 0x7FF0, then 0x8000.
- BYPASS=0, ADC_CH held 0x800, then stepped to 0xC00 -> step output 0x4000 (16384), next 16368, each following sample y - (y>>>10), decaying toward 0.
- BYPASS=0, ADC_CH settled at 0x000 for >50000 samples, then stepped to 0xFFF -> output saturates to 0x7FFF; no wrap to negative.
- READY=0 for 6 sample periods -> 4 samples buffered, OVERFLOW=1 at 5th push; with READY=1, oldest 4 pop in order. CLEAR_OVF -> OVERFLOW=0.
- RESET low with 3 samples buffered -> SAMPLE_VALID=0, OVERFLOW=0 immediately (asynchronous). After release, next sample appears DIV+3 cycles later with blocker state zeroed.
